// File: rtl/mx_scale_acc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mx_scale_acc                                                |
// | Purpose  : Streams FP32 lanes of one MX block, tracks the largest      |
// |            finite exponent plus NaN/Inf presence, and emits the E8M0   |
// |            shared scale for the block with a valid/ready handshake.    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module mx_scale_acc #(
  parameter int BLOCK_SIZE = 32,
  parameter int LANES      = 4,
  parameter int ELEM_EMAX  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_scale,
  output logic                  out_nan,
  output logic                  out_inf
);

  localparam int              BEATS    = BLOCK_SIZE / LANES;
  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [7:0]      EMAX8    = 8'(ELEM_EMAX);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  // A block must split into a whole number of beats.
  generate
    if ((LANES < 1) || (BLOCK_SIZE < LANES) || ((BLOCK_SIZE % LANES) != 0)) begin : g_bad_cfg
      $error("mx_scale_acc: BLOCK_SIZE must be a positive multiple of LANES");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Per-lane field decode (sign bits are irrelevant to the scale)
  // ---------------------------------------------------------------------
  logic [7:0]       w_lane_exp [LANES];
  logic [LANES-1:0] w_lane_nan;
  logic [LANES-1:0] w_lane_inf;
  logic [LANES-1:0] w_unused_sign;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign w_lane_exp[k]    = in_data[32*k+23 +: 8];
      assign w_lane_nan[k]    = (&in_data[32*k+23 +: 8]) &  (|in_data[32*k +: 23]);
      assign w_lane_inf[k]    = (&in_data[32*k+23 +: 8]) & ~(|in_data[32*k +: 23]);
      assign w_unused_sign[k] = in_data[32*k+31];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [7:0]       max_q,   max_d;
  logic             nan_q,   nan_d;
  logic             inf_q,   inf_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       scale_q, scale_d;
  logic             onan_q,  onan_d;
  logic             oinf_q,  oinf_d;

  logic [7:0] w_beat_max;
  logic [7:0] w_max_merged;
  logic       w_nan_merged;
  logic       w_inf_merged;
  logic       w_accept;
  logic       w_last;

  // Largest finite exponent in the current beat; exp 255 lanes are excluded.
  always_comb begin
    w_beat_max = 8'd0;
    for (int k = 0; k < LANES; k++) begin
      if ((w_lane_exp[k] != 8'hFF) && (w_lane_exp[k] > w_beat_max)) begin
        w_beat_max = w_lane_exp[k];
      end
    end
  end

  // Merge the incoming beat with the running accumulator so the final beat
  // is already included when the result is captured.
  always_comb begin
    w_max_merged = (w_beat_max > max_q) ? w_beat_max : max_q;
    w_nan_merged = nan_q | (|w_lane_nan);
    w_inf_merged = inf_q | (|w_lane_inf);
    w_accept     = in_valid & in_ready;
    w_last       = w_accept & (cnt_q == LAST_CNT);
  end

  // ---------------------------------------------------------------------
  // FSM: ACCUM (no result pending) / HOLD (result presented)
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a final beat always lands in HOLD, even while the previous
  // result is being consumed in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: begin
        if (w_last) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (w_last)         state_d = S_HOLD;
        else if (out_ready) state_d = S_ACCUM;
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // Outputs: accept a beat whenever no result is stuck waiting.
  always_comb begin
    out_valid = (state_q == S_HOLD);
    in_ready  = ~out_valid | out_ready;
    out_scale = scale_q;
    out_nan   = onan_q;
    out_inf   = oinf_q;
  end

  // ---------------------------------------------------------------------
  // Accumulator and result datapath
  // ---------------------------------------------------------------------

  // Next accumulator value: cleared after the final beat, else merged.
  always_comb begin
    max_d = max_q;
    nan_d = nan_q;
    inf_d = inf_q;
    cnt_d = cnt_q;
    if (w_last) begin
      max_d = 8'd0;
      nan_d = 1'b0;
      inf_d = 1'b0;
      cnt_d = '0;
    end else if (w_accept) begin
      max_d = w_max_merged;
      nan_d = w_nan_merged;
      inf_d = w_inf_merged;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Scale encoding: NaN dominates Inf; otherwise the exponent is shifted
  // down by the element format's max exponent and floored at zero.
  always_comb begin
    scale_d = scale_q;
    onan_d  = onan_q;
    oinf_d  = oinf_q;
    if (w_last) begin
      onan_d = 1'b0;
      oinf_d = 1'b0;
      if (w_nan_merged) begin
        scale_d = 8'hFF;
        onan_d  = 1'b1;
      end else if (w_inf_merged) begin
        scale_d = 8'hFF;
        oinf_d  = 1'b1;
      end else if (w_max_merged <= EMAX8) begin
        scale_d = 8'd0;
      end else begin
        scale_d = w_max_merged - EMAX8;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= 8'd0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      cnt_q   <= '0;
      scale_q <= 8'd0;
      onan_q  <= 1'b0;
      oinf_q  <= 1'b0;
    end else begin
      max_q   <= max_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      cnt_q   <= cnt_d;
      scale_q <= scale_d;
      onan_q  <= onan_d;
      oinf_q  <= oinf_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mx_scale_acc.md
MX_SCALE_ACC -- requirements
Module: mx_scale_acc

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 32, elements per MX block.
REQ-002 SHALL have parameter LANES, default 4, FP32 elements per input beat; BLOCK_SIZE SHALL be a multiple of LANES, checked at elaboration.
REQ-003 SHALL have parameter ELEM_EMAX, default 2, unbiased max exponent of the element format (2 = E2M3).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_data  input  32*LANES  FP32 lanes; lane k at bits [32k+31:32k].
REQ-009 out_valid  output  1  shared scale available.
REQ-010 out_ready  input  1  consumer accepts scale.
REQ-011 out_scale  output  8  E8M0 biased shared scale.
REQ-012 out_nan  output  1  block contained at least one NaN.
REQ-013 out_inf  output  1  block contained at least one Inf and no NaN.

Function
REQ-014 Beat accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-015 in_ready SHALL equal ~out_valid | out_ready (combinational).
REQ-016 Per lane: exp = bits[30:23], man = bits[22:0]; sign ignored; NaN = exp 255 and man != 0; Inf = exp 255 and man = 0.
REQ-017 Running state: max_exp (8b, max over finite lanes only), nan_seen, inf_seen, beat counter 0..BLOCK_SIZE/LANES-1.
REQ-018 On each accepted beat, max_exp SHALL become the max of max_exp and all finite lane exponents; nan_seen/inf_seen SHALL OR in the lane flags; counter SHALL increment.
REQ-019 On the accepted beat with counter = BLOCK_SIZE/LANES-1, the next edge SHALL register the result, assert out_valid, and clear the accumulator and counter (latency 1 cycle from last beat).
REQ-020 Result: if nan_seen, out_scale = 8'hFF, out_nan = 1; else if inf_seen, out_scale = 8'hFF, out_inf = 1; else if max_exp <= ELEM_EMAX, out_scale = 0; else out_scale = max_exp - ELEM_EMAX.
REQ-021 Flags and max SHALL include the final beat itself (merged combinationally before registering).
REQ-022 out_valid, out_scale, out_nan and out_inf SHALL hold stable while out_valid & ~out_ready.
REQ-023 On consume without a same-cycle completion, out_valid SHALL drop next edge.
REQ-024 Simultaneous consume and final beat of the next block: out_valid SHALL stay 1 with the new result next edge.
REQ-025 A beat accepted in the same cycle as a consume SHALL be counted into the new block; no beat is lost or double-counted.
REQ-026 Subnormal and zero lanes have exp 0 and contribute 0 to max_exp; an all-zero block yields out_scale = 0.
REQ-027 Two-state FSM: ACCUM (out_valid = 0) and HOLD (out_valid = 1); ACCUM->HOLD on final beat; HOLD->ACCUM on consume without a final beat; HOLD->HOLD otherwise.

Reset
REQ-028 rst_n low SHALL immediately clear out_valid, out_scale, out_nan, out_inf, max_exp, nan_seen, inf_seen, counter; FSM to ACCUM; in_ready = 1 while in reset-released ACCUM.
REQ-029 Reset asserted mid-block SHALL discard the partial block; the first beat after release starts a new block.

Verification
REQ-030 LANES=4, BLOCK_SIZE=32: 8 beats of 1.0 (exp 127), one lane in beat 5 = 6.0 (exp 129) -> out_scale 127 one cycle after beat 8, flags 0.
REQ-031 Block with one lane = 0x7FC00000 (NaN) and another = +Inf -> out_scale 8'hFF, out_nan 1, out_inf 0.
REQ-032 All-zero block -> out_scale 0; block with max exp 2 -> out_scale 0; max exp 254 -> out_scale 252.
REQ-033 out_ready held low 5 cycles after out_valid -> in_ready 0, outputs stable; then out_ready 1 with in_valid 1 -> beat accepted same cycle, next block result correct.
REQ-034 Back-to-back blocks with out_ready constantly 1 and in_valid constantly 1 -> one result per 8 cycles, no stall.
REQ-035 rst_n pulsed low after beat 3 of a block -> outputs 0 immediately; following 8 beats produce a result based only on those beats.
